// File: rtl/aha_sram_ctrl_pkg.sv
// Shared definitions for the AHA AHB-Lite SRAM controller.
//   - AHB HTRANS / HSIZE encodings
//   - SRAM_DW: SRAM macro data width (64)
//   - err_state_e: error-response FSM states (used when AHA_SRAM_CTRL_ERR_EN is defined)
//   - byte_mask(): 8-bit SRAM byte-lane mask for an AHB transfer
package aha_sram_ctrl_pkg;

  localparam int SRAM_DW = 64;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic [1:0] {
    ERR_IDLE   = 2'd0,
    ERR_FIRST  = 2'd1,
    ERR_SECOND = 2'd2
  } err_state_e;

  // Lane mask of the transfer, placed at byte lane addr_lo of the 64-bit word.
  // Callers pass an already size-aligned addr_lo.
  function automatic logic [7:0] byte_mask(input logic [2:0] hsize,
                                           input logic [2:0] addr_lo);
    logic [7:0] base;
    case (hsize)
      HSIZE_BYTE: base = 8'h01;
      HSIZE_HALF: base = 8'h03;
      default:    base = 8'h0F;
    endcase
    return base << addr_lo;
  endfunction

endpackage

// File: rtl/aha_sram_wbuf.sv
// One-entry write buffer with read-merge.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset (discards the entry)
//   capture_i          load addr/mask/data and mark valid (wins over drain)
//   drain_i            entry is being written to SRAM this cycle; clear valid
//   addr_i/mask_i/data_i  entry contents to capture
//   rd_addr_i          word address of the read in its data phase
//   q_i                raw SRAM read data
//   merged_o           q_i with buffered bytes substituted on an address hit
//   buf_valid_o, buf_addr_o, buf_mask_o, buf_data_o  entry state for the drain path
module aha_sram_wbuf
  import aha_sram_ctrl_pkg::*;
#(
  parameter int WAW = 12
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               capture_i,
  input  logic               drain_i,
  input  logic [WAW-1:0]     addr_i,
  input  logic [7:0]         mask_i,
  input  logic [SRAM_DW-1:0] data_i,
  input  logic [WAW-1:0]     rd_addr_i,
  input  logic [SRAM_DW-1:0] q_i,
  output logic [SRAM_DW-1:0] merged_o,
  output logic               buf_valid_o,
  output logic [WAW-1:0]     buf_addr_o,
  output logic [7:0]         buf_mask_o,
  output logic [SRAM_DW-1:0] buf_data_o
);

  logic               buf_valid_q;
  logic [WAW-1:0]     buf_addr_q;
  logic [7:0]         buf_mask_q;
  logic [SRAM_DW-1:0] buf_data_q;
  logic               hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_mask_q  <= '0;
      buf_data_q  <= '0;
    end else if (capture_i) begin
      buf_valid_q <= 1'b1;
      buf_addr_q  <= addr_i;
      buf_mask_q  <= mask_i;
      buf_data_q  <= data_i;
    end else if (drain_i) begin
      buf_valid_q <= 1'b0;
    end
  end

  // The entry stays valid through its drain cycle, so a read issued before the
  // drain still picks up the newer bytes here.
  always_comb begin
    merged_o = q_i;
    hit      = buf_valid_q && (buf_addr_q == rd_addr_i);
    for (int b = 0; b < 8; b++) begin
      if (hit && buf_mask_q[b]) merged_o[b*8 +: 8] = buf_data_q[b*8 +: 8];
    end
  end

  assign buf_valid_o = buf_valid_q;
  assign buf_addr_o  = buf_addr_q;
  assign buf_mask_o  = buf_mask_q;
  assign buf_data_o  = buf_data_q;

endmodule

// File: rtl/aha_ahb_sram_ctrl.sv
// Zero-wait-state AHB-Lite slave in front of a 4K x 64 SRAM macro.
// Reads issue to the SRAM in the AHB address phase; writes land in a one-entry
// buffer that drains in the next cycle without an accepted read.
// Optional macro AHA_SRAM_CTRL_ERR_EN: illegal size / misaligned transfers get a
// two-cycle ERROR response; otherwise sizes > word act as word and the low
// address bits are aligned down.
// Ports:
//   CLK, RESET                       clock, synchronous active-high reset
//   HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY   AHB-Lite slave inputs
//   HREADYOUT, HRESP, HRDATA         AHB-Lite slave outputs
//   SRAM_CEn, SRAM_WEn, SRAM_A, SRAM_D  SRAM macro controls (active low)
//   SRAM_Q                           SRAM read data, one cycle after CEn low
// Handshake: a transfer is taken when HSEL & HTRANS[1] & HREADY; its data phase
// is the following cycle and completes there unless HREADYOUT is low.
module aha_ahb_sram_ctrl
  import aha_sram_ctrl_pkg::*;
#(
  parameter int AW = 15,
  parameter int DW = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            HSEL,
  input  logic [AW-1:0]   HADDR,
  input  logic [1:0]      HTRANS,
  input  logic            HWRITE,
  input  logic [2:0]      HSIZE,
  input  logic [DW-1:0]   HWDATA,
  input  logic            HREADY,
  output logic            HREADYOUT,
  output logic            HRESP,
  output logic [DW-1:0]   HRDATA,
  output logic            SRAM_CEn,
  output logic [7:0]      SRAM_WEn,
  output logic [AW-4:0]   SRAM_A,
  output logic [2*DW-1:0] SRAM_D,
  input  logic [2*DW-1:0] SRAM_Q
);

  localparam int WAW = AW - 3;

  logic           accept, bad, xfer_ok, rd_accept, wr_accept, drain;
  logic [2:0]     addr_lo;
  logic [7:0]     mask;
  logic           rd_pending_q, rd_hi_q, wr_pending_q;
  logic [WAW-1:0] rd_addr_q, wr_addr_q;
  logic [7:0]     wr_mask_q;
  logic [2*DW-1:0] merged, buf_data;
  logic           buf_valid;
  logic [WAW-1:0] buf_addr;
  logic [7:0]     buf_mask;

  assign accept = HSEL & HTRANS[1] & HREADY & ~RESET;

`ifdef AHA_SRAM_CTRL_ERR_EN
  assign addr_lo = HADDR[2:0];
  assign bad     = (HSIZE > 3'd2) ||
                   ((HSIZE == 3'd1) && HADDR[0]) ||
                   ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
  assign mask    = byte_mask(HSIZE, addr_lo);
`else
  logic [2:0] eff_size;
  always_comb begin
    eff_size = (HSIZE > 3'd2) ? HSIZE_WORD : HSIZE;
    case (eff_size)
      HSIZE_HALF: addr_lo = {HADDR[2:1], 1'b0};
      HSIZE_WORD: addr_lo = {HADDR[2], 2'b00};
      default:    addr_lo = HADDR[2:0];
    endcase
  end
  assign bad  = 1'b0;
  assign mask = byte_mask(eff_size, addr_lo);
`endif

  assign xfer_ok   = accept & ~bad;
  assign rd_accept = xfer_ok & ~HWRITE;
  assign wr_accept = xfer_ok & HWRITE;
  // A read owns the SRAM port; during reset nothing reaches the macro.
  assign drain     = buf_valid & ~rd_accept & ~RESET;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_pending_q <= 1'b0;
      rd_hi_q      <= 1'b0;
      rd_addr_q    <= '0;
      wr_pending_q <= 1'b0;
      wr_addr_q    <= '0;
      wr_mask_q    <= '0;
    end else begin
      rd_pending_q <= rd_accept;
      wr_pending_q <= wr_accept;
      if (rd_accept) begin
        rd_addr_q <= HADDR[AW-1:3];
        rd_hi_q   <= HADDR[2];
      end
      if (wr_accept) begin
        wr_addr_q <= HADDR[AW-1:3];
        wr_mask_q <= mask;
      end
    end
  end

  // The write address phase never carries a read, so the entry has always
  // drained before this capture: no stall is needed.
  aha_sram_wbuf #(.WAW(WAW)) u_wbuf (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .capture_i   (wr_pending_q),
    .drain_i     (drain),
    .addr_i      (wr_addr_q),
    .mask_i      (wr_mask_q),
    .data_i      ({HWDATA, HWDATA}),
    .rd_addr_i   (rd_addr_q),
    .q_i         (SRAM_Q),
    .merged_o    (merged),
    .buf_valid_o (buf_valid),
    .buf_addr_o  (buf_addr),
    .buf_mask_o  (buf_mask),
    .buf_data_o  (buf_data)
  );

  always_comb begin
    SRAM_CEn = 1'b1;
    SRAM_WEn = 8'hFF;
    SRAM_A   = buf_addr;
    SRAM_D   = buf_data;
    if (rd_accept) begin
      SRAM_CEn = 1'b0;
      SRAM_A   = HADDR[AW-1:3];
    end else if (drain) begin
      SRAM_CEn = 1'b0;
      SRAM_WEn = ~buf_mask;
    end
  end

  always_comb begin
    HRDATA = '0;
    if (rd_pending_q && !RESET) HRDATA = rd_hi_q ? merged[2*DW-1:DW] : merged[DW-1:0];
  end

`ifdef AHA_SRAM_CTRL_ERR_EN
  err_state_e err_state_q, err_state_d;

  always_ff @(posedge CLK) begin
    if (RESET) err_state_q <= ERR_IDLE;
    else       err_state_q <= err_state_d;
  end

  always_comb begin
    err_state_d = err_state_q;
    HREADYOUT   = 1'b1;
    HRESP       = 1'b0;
    case (err_state_q)
      ERR_IDLE: if (accept && bad) err_state_d = ERR_FIRST;
      ERR_FIRST: begin
        HREADYOUT   = 1'b0;
        HRESP       = 1'b1;
        err_state_d = ERR_SECOND;
      end
      ERR_SECOND: begin
        HRESP       = 1'b1;
        err_state_d = (accept && bad) ? ERR_FIRST : ERR_IDLE;
      end
      default: err_state_d = ERR_IDLE;
    endcase
  end
`else
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
`endif

endmodule

// File: tb/tb_aha_ahb_sram_ctrl.sv
// Directed bench for aha_ahb_sram_ctrl with a behavioural 4K x 64 SRAM model.
// SRAM word i is preloaded with {32'h55667700 + i, 32'h11223300 + i}.
module tb_aha_ahb_sram_ctrl;
  import aha_sram_ctrl_pkg::*;

  // clock / reset
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RESET, HSEL, HWRITE, HREADY;
  logic [14:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADYOUT, HRESP, SRAM_CEn;
  logic [31:0] HRDATA;
  logic [7:0]  SRAM_WEn;
  logic [11:0] SRAM_A;
  logic [63:0] SRAM_D;
  logic [63:0] SRAM_Q = '0;

  aha_ahb_sram_ctrl dut (
    .CLK(CLK), .RESET(RESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .SRAM_CEn(SRAM_CEn), .SRAM_WEn(SRAM_WEn), .SRAM_A(SRAM_A),
    .SRAM_D(SRAM_D), .SRAM_Q(SRAM_Q)
  );

  // SRAM macro model plus a count of write cycles
  logic [63:0] mem [4096];
  int n_wr = 0;
  always @(posedge CLK) begin
    if (!SRAM_CEn) begin
      if (SRAM_WEn == 8'hFF) SRAM_Q <= mem[SRAM_A];
      else begin
        n_wr++;
        for (int b = 0; b < 8; b++)
          if (!SRAM_WEn[b]) mem[SRAM_A][b*8 +: 8] <= SRAM_D[b*8 +: 8];
      end
    end
  end

  // scoreboard counters
  int n_vec = 0;
  int n_err = 0;
  int wr_base;

  logic [14:0] raddr [10] = '{15'h30, 15'h34, 15'h38, 15'h30, 15'h30,
                              15'h34, 15'h3C, 15'h30, 15'h34, 15'h30};
  logic [31:0] rexp  [10] = '{32'hCAFEF00D, 32'h55667706, 32'h11223307, 32'hCAFEF00D, 32'hCAFEF00D,
                              32'h55667706, 32'h55667707, 32'hCAFEF00D, 32'h55667706, 32'hCAFEF00D};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: drive just after posedge, return at the following negedge
  task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [2:0] size, input logic [14:0] addr, input logic [31:0] wdata);
    HSEL = sel; HTRANS = trans; HWRITE = wr; HSIZE = size; HADDR = addr; HWDATA = wdata;
    @(negedge CLK);
  endtask

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input logic [31:0] wdata);
    drive(1'b0, HTRANS_IDLE, 1'b0, 3'd0, 15'h0, wdata);
  endtask

  task automatic rd(input logic [14:0] addr, input logic [31:0] wdata);
    drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, addr, wdata);
  endtask

  task automatic wr(input logic [2:0] size, input logic [14:0] addr);
    drive(1'b1, HTRANS_NONSEQ, 1'b1, size, addr, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = {32'h55667700 + 32'(i), 32'h11223300 + 32'(i)};
    RESET = 1'b1; HREADY = 1'b1;
    HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HSIZE = 3'd0; HADDR = '0; HWDATA = '0;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;

    // reset state
    idle(32'h0);
    chk("rst_hreadyout", 64'(HREADYOUT), 64'h1);
    chk("rst_hresp", 64'(HRESP), 64'h0);
    chk("rst_cen", 64'(SRAM_CEn), 64'h1);
    chk("rst_wen", 64'(SRAM_WEn), 64'hFF);
    chk("rst_hrdata", 64'(HRDATA), 64'h0);
    adv();

    // word write 0xDEADBEEF @0x10, drain, read back
    wr(HSIZE_WORD, 15'h0010); chk("w1_aphase_cen", 64'(SRAM_CEn), 64'h1); adv();
    idle(32'hDEADBEEF);       chk("w1_dphase_cen", 64'(SRAM_CEn), 64'h1); adv();
    idle(32'h0);
    chk("w1_drain_cen", 64'(SRAM_CEn), 64'h0);
    chk("w1_drain_a", 64'(SRAM_A), 64'h2);
    chk("w1_drain_wen", 64'(SRAM_WEn), 64'hF0);
    chk("w1_drain_d", SRAM_D, 64'hDEADBEEF_DEADBEEF);
    adv();
    rd(15'h0010, 32'h0);
    chk("r1_cen", 64'(SRAM_CEn), 64'h0);
    chk("r1_wen", 64'(SRAM_WEn), 64'hFF);
    chk("r1_a", 64'(SRAM_A), 64'h2);
    adv();
    idle(32'h0);
    chk("r1_hrdata", 64'(HRDATA), 64'hDEADBEEF);
    chk("r1_after_cen", 64'(SRAM_CEn), 64'h1);
    adv();

    // write then back-to-back read of the same word: merge, then deferred drain
    wr(HSIZE_WORD, 15'h0024); adv();
    rd(15'h0024, 32'h11223344);
    chk("b2b_rd_cen", 64'(SRAM_CEn), 64'h0);
    chk("b2b_rd_wen", 64'(SRAM_WEn), 64'hFF);
    chk("b2b_rd_a", 64'(SRAM_A), 64'h4);
    adv();
    idle(32'h0);
    chk("b2b_hrdata", 64'(HRDATA), 64'h11223344);
    chk("b2b_drain_cen", 64'(SRAM_CEn), 64'h0);
    chk("b2b_drain_wen", 64'(SRAM_WEn), 64'h0F);
    chk("b2b_drain_a", 64'(SRAM_A), 64'h4);
    adv();
    idle(32'h0); chk("b2b_done_cen", 64'(SRAM_CEn), 64'h1); adv();

    // byte write 0xAB @0x07, then word read @0x04
    wr(HSIZE_BYTE, 15'h0007); adv();
    idle(32'hAB000000); adv();
    idle(32'h0);
    chk("byte_drain_wen", 64'(SRAM_WEn), 64'h7F);
    chk("byte_drain_a", 64'(SRAM_A), 64'h0);
    chk("byte_drain_d", SRAM_D, 64'hAB000000_AB000000);
    adv();
    rd(15'h0004, 32'h0); adv();
    idle(32'h0); chk("byte_hrdata", 64'(HRDATA), 64'hAB667700); adv();

    // write followed by ten reads: buffer held, merged throughout, then reset
    wr(HSIZE_WORD, 15'h0030); adv();
    wr_base = n_wr;
    for (int i = 0; i < 10; i++) begin
      rd(raddr[i], (i == 0) ? 32'hCAFEF00D : 32'h0);
      chk("burst_cen", 64'(SRAM_CEn), 64'h0);
      chk("burst_wen", 64'(SRAM_WEn), 64'hFF);
      chk("burst_a", 64'(SRAM_A), 64'(raddr[i][14:3]));
      if (i > 0) chk("burst_hrdata", 64'(HRDATA), 64'(rexp[i-1]));
      adv();
    end
    RESET = 1'b1;
    idle(32'h0);
    chk("midrst_cen", 64'(SRAM_CEn), 64'h1);
    chk("midrst_hrdata", 64'(HRDATA), 64'h0);
    adv();
    RESET = 1'b0;
    idle(32'h0); chk("postrst_cen", 64'(SRAM_CEn), 64'h1); adv();
    rd(15'h0030, 32'h0); adv();
    idle(32'h0);
    chk("postrst_hrdata", 64'(HRDATA), 64'h11223306);
    chk("postrst_no_write", 64'(n_wr - wr_base), 64'h0);
    adv();

`ifdef AHA_SRAM_CTRL_ERR_EN
    // misaligned word access gets a two-cycle ERROR and no SRAM access
    rd(15'h0002, 32'h0);
    chk("err_aphase_cen", 64'(SRAM_CEn), 64'h1);
    adv();
    HREADY = 1'b0;
    idle(32'h0);
    chk("err1_hreadyout", 64'(HREADYOUT), 64'h0);
    chk("err1_hresp", 64'(HRESP), 64'h1);
    chk("err1_cen", 64'(SRAM_CEn), 64'h1);
    adv();
    HREADY = 1'b1;
    idle(32'h0);
    chk("err2_hreadyout", 64'(HREADYOUT), 64'h1);
    chk("err2_hresp", 64'(HRESP), 64'h1);
    chk("err2_cen", 64'(SRAM_CEn), 64'h1);
    chk("err2_hrdata", 64'(HRDATA), 64'h0);
    adv();
    idle(32'h0); chk("err_done_hresp", 64'(HRESP), 64'h0); adv();
`else
    // misaligned word access is aligned down to 0x0000
    wr(HSIZE_WORD, 15'h0002);
    chk("align_hresp", 64'(HRESP), 64'h0);
    chk("align_hreadyout", 64'(HREADYOUT), 64'h1);
    adv();
    idle(32'h0BADF00D); adv();
    idle(32'h0);
    chk("align_drain_cen", 64'(SRAM_CEn), 64'h0);
    chk("align_drain_a", 64'(SRAM_A), 64'h0);
    chk("align_drain_wen", 64'(SRAM_WEn), 64'hF0);
    chk("align_drain_d", SRAM_D, 64'h0BADF00D_0BADF00D);
    adv();
    rd(15'h0002, 32'h0); chk("align_rd_a", 64'(SRAM_A), 64'h0); adv();
    idle(32'h0); chk("align_hrdata", 64'(HRDATA), 64'h0BADF00D); adv();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
